// File: rtl/byteblast_pkg.sv
// byteblast_pkg: shared definitions for the ByteBlast8 core.
//   - ADDR_W / DATA_W : RAM address width and data/accumulator width
//   - OP_LD / OP_ADD / OP_STR : instruction opcodes (every other code is a NOP)
//   - exec_state_t : execute-stage FSM states
package byteblast_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_STR = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } exec_state_t;

endpackage

// File: rtl/exec_unit_alu8.sv
// alu8: combinational adder with carry out and zero detect.
//   a_i, b_i  : operands
//   sum_o     : (a_i + b_i) modulo 2**WIDTH
//   carry_o   : carry out of the addition
//   zero_o    : sum_o == 0
// Kept as its own block so later SUB/AND operations can extend it.
module alu8
  import byteblast_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             zero_o
);

  logic [WIDTH:0] full_sum;

  // Widen both operands by one bit so the carry lands in the MSB.
  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o    = full_sum[WIDTH-1:0];
  assign carry_o  = full_sum[WIDTH];
  assign zero_o   = (full_sum[WIDTH-1:0] == '0);

endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage of the ByteBlast8 core and write side of the
// shared RAM port.
//   clk, reset        : clock; synchronous active-high reset
//   start             : one-cycle request, samples opcode/operand in IDLE
//   opcode, operand   : decoded instruction
//   ram_data          : RAM read data, valid one cycle after the address
//   o_address         : read/write address (last latched operand)
//   w_enable, w_data  : RAM write port (w_data is always acc)
//   acc, carry, zero  : accumulator and flags
//   busy, done        : not-IDLE indicator; one-cycle completion pulse
module exec_unit
  import byteblast_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDR_W,
  parameter int DATA_BITS    = DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2:0]              opcode,
  input  logic [ADDRESS_BITS-1:0] operand,
  input  logic [DATA_BITS-1:0]    ram_data,
  output logic [ADDRESS_BITS-1:0] o_address,
  output logic                    w_enable,
  output logic [DATA_BITS-1:0]    w_data,
  output logic [DATA_BITS-1:0]    acc,
  output logic                    carry,
  output logic                    zero,
  output logic                    busy,
  output logic                    done
);

  exec_state_t             state_q, state_d;
  logic [2:0]              opcode_q;
  logic [ADDRESS_BITS-1:0] address_q;
  logic [DATA_BITS-1:0]    acc_q, acc_d;
  logic                    carry_q, carry_d;
  logic                    zero_q, zero_d;

  logic                    accept;
  logic [DATA_BITS-1:0]    alu_a;
  logic [DATA_BITS-1:0]    alu_sum;
  logic                    alu_carry;
  logic                    alu_zero;

  // A request is only taken in IDLE; start while busy or in DONE is dropped.
  assign accept = (state_q == ST_IDLE) && start;

  // LD is computed as 0 + ram_data so the same adder supplies the zero flag.
  assign alu_a = (opcode_q == OP_ADD) ? acc_q : '0;

  alu8 #(
    .WIDTH (DATA_BITS)
  ) u_alu (
    .a_i     (alu_a),
    .b_i     (ram_data),
    .sum_o   (alu_sum),
    .carry_o (alu_carry),
    .zero_o  (alu_zero)
  );

  // Next-state and datapath update.
  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (opcode == OP_LD || opcode == OP_ADD) begin
            state_d = ST_READ;
          end else if (opcode == OP_STR) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        acc_d  = alu_sum;
        zero_d = alu_zero;
        // LD leaves carry alone; only ADD produces a new carry.
        if (opcode_q == OP_ADD) begin
          carry_d = alu_carry;
        end
        state_d = ST_DONE;
      end
      ST_WRITE:   state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      address_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      if (accept) begin
        opcode_q  <= opcode;
        address_q <= operand;
      end
    end
  end

  // Moore decodes: no combinational path from inputs to these outputs.
  assign w_enable  = (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign o_address = address_q;
  assign w_data    = acc_q;
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage of the ByteBlast8 core and the write side of the shared RAM port. It takes a decoded instruction (3-bit opcode, 5-bit operand address) from `ctrl` when the `fde` execute phase starts it. It reads operands through mux4 input `c`, maintains the accumulator and flags, and drives the RAM write port (`enable`, `address`, `data_in`) for STR.

## Interface
- `ADDRESS_BITS`, 5, RAM address width.
- `DATA_BITS`, 8, data, accumulator and RAM word width.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `start`  in  1  one-cycle request from the `fde` execute phase.
- `opcode`  in  3  instruction opcode, sampled with `start`.
- `operand`  in  ADDRESS_BITS  operand address from `ctrl.o_address`, sampled with `start`.
- `ram_data`  in  DATA_BITS  RAM `data_out`; valid one cycle after the address is presented.
- `o_address`  out  ADDRESS_BITS  address to mux4 input `c` and RAM write address.
- `w_enable`  out  1  RAM write enable.
- `w_data`  out  DATA_BITS  RAM `data_in`.
- `acc`  out  DATA_BITS  accumulator.
- `carry`  out  1  carry out of the last ADD.
- `zero`  out  1  set when `acc` is 0 after LD or ADD.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Opcodes: 001 LD (`acc` ← mem[operand]); 010 ADD (`acc` ← `acc` + mem[operand]); 100 STR (mem[operand] ← `acc`). Every other opcode is a NOP.
- FSM states: IDLE, READ, CAPTURE, WRITE, DONE.
  - IDLE with `start`=1: latch `opcode` and `operand`. Go to READ for LD/ADD, WRITE for STR, DONE for a NOP.
  - IDLE with `start`=0: stay in IDLE.
  - READ: `o_address` = latched operand; RAM registers the address on this edge. Next state CAPTURE.
  - CAPTURE: `ram_data` is valid.
    - LD: `acc` ← `ram_data`; `carry` is unchanged.
    - ADD: {`carry`,`acc`} ← `acc` + `ram_data`, computed 9 bits wide; result wraps modulo 256.
    - `zero` ← (new `acc` == 0).
    - Next state DONE.
  - WRITE: `w_enable`=1, `w_data`=`acc`, `o_address`=operand. RAM stores on this edge. Next state DONE.
  - DONE: `done`=1. Next state IDLE.
- `w_enable`, `done` and `busy` are Moore decodes of the state register; no combinational path from inputs.
- `o_address` is a register that holds the last latched operand. `w_data` is always `acc`.
- STR leaves `acc`, `carry` and `zero` unchanged.

## Timing
- Reset values: state IDLE; `acc`, `o_address`, `carry`, `zero`, `w_enable`, `busy`, `done` all 0; `w_data` 0.
- Latency from the `start` edge to the `done` pulse: LD/ADD 3 cycles, STR 2 cycles, NOP 1 cycle.
- `start` while `busy` is ignored and never queued. `start` in the same cycle as DONE is also ignored.
- `reset` during any state returns to IDLE on that edge. A WRITE interrupted by reset still writes on that edge, because reset and RAM see the same edge. No `done` is issued for the aborted instruction.
- `reset` has priority over `start` in the same cycle.
- `w_enable` is high for exactly one cycle per STR.

## Structure
- Shared package `byteblast_pkg`:
  - opcode constants OP_LD, OP_ADD, OP_STR;
  - FSM state enum `exec_state_t`;
  - width constants ADDR_W=5, DATA_W=8.
- One natural sub-module: `alu8`, a combinational 8-bit adder with carry out, producing the sum and zero result. It is reusable by a later SUB/AND extension.

## Test plan
- Load RAM[3]=2; LD 3 (start, opcode 001, operand 3). Expect `o_address`=3 in READ, and `acc`=2, `zero`=0 at the `done` pulse three cycles after start.
- Load RAM[4]=5; ADD 4 after the previous LD. Expect `acc`=7, `carry`=0, `zero`=0.
- STR 5 with `acc`=7. Expect `w_enable`=1 for exactly one cycle with `o_address`=5 and `w_data`=7; RAM[5] reads back 7; `done` two cycles after start.
- Set `acc`=200 and RAM[6]=56, then ADD 6. Expect `acc`=0, `carry`=1, `zero`=1.
- Pulse `start` again during READ, and give opcode 000 in IDLE. Expect the second `start` ignored, and the NOP to produce `done` the cycle after start with no state change.
- Assert `reset` during CAPTURE of an ADD. Expect IDLE next cycle, all outputs at their reset values, and no `done` for the aborted ADD.
